// File: rtl/hbm_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR + R) among NUM_REQ column requesters.
// One burst is in flight at a time; R beats are steered back to the granted column.
module hbm_rd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int GID_W   = 1
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]      req_arlen,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_rlast,
    input  logic [NUM_REQ-1:0]        req_rready,
    output logic                      m_axi_arvalid,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    input  logic                      m_axi_arready,
    input  logic                      m_axi_rvalid,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic                      m_axi_rlast,
    output logic                      m_axi_rready,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GID_W-1:0]    last_grant_q, last_grant_d;
    logic [GID_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [8:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [GID_W-1:0]    cand_s [NUM_REQ];
    logic                pick_found_s;
    logic [GID_W-1:0]    pick_id_s;
    logic [NUM_REQ-1:0]  arready_s;
    logic [NUM_REQ-1:0]  rvalid_s;
    logic                rready_s;
    logic [DATA_W-1:0]   rdata_s;
    logic                rlast_s;

    // Round-robin pick: first valid column above last_grant, wrapping around
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s[k] = GID_W'((int'(last_grant_q) + k + 1) % NUM_REQ);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found_s && req_arvalid[cand_s[k]]) begin
                pick_found_s = 1'b1;
                pick_id_s    = cand_s[k];
            end else begin
                pick_id_s    = pick_id_s;
            end
        end
    end

    // Next-state, request capture and zero-latency steering of the R channel
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        arready_s    = '0;
        rvalid_s     = '0;
        rready_s     = 1'b0;
        rdata_s      = '0;
        rlast_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    arready_s[pick_id_s] = 1'b1;
                    addr_d  = req_araddr[int'(pick_id_s)*ADDR_W +: ADDR_W];
                    len_d   = req_arlen[int'(pick_id_s)*8 +: 8];
                    grant_d = pick_id_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    cnt_d   = 9'd0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                rvalid_s[grant_q] = m_axi_rvalid;
                rready_s          = req_rready[grant_q];
                rdata_s           = m_axi_rdata;
                rlast_s           = m_axi_rlast;
                if (m_axi_rvalid && rready_s) begin
                    cnt_d = cnt_q + 9'd1;
                    // cnt_q is the index of this beat; beat arlen must be the one carrying rlast
                    if (m_axi_rlast) begin
                        err_d        = err_q | (cnt_q != {1'b0, len_q});
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        err_d        = err_q | (cnt_q == {1'b0, len_q});
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; areset abandons any burst in flight
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            len_q        <= 8'd0;
            cnt_q        <= 9'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign req_arready   = arready_s & {NUM_REQ{~areset}};
    assign req_rvalid    = rvalid_s;
    assign req_rdata     = rdata_s;
    assign req_rlast     = rlast_s;
    assign m_axi_rready  = rready_s;
    assign m_axi_arvalid = (state_q == ST_ADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// Self-checking bench for hbm_rd_arbiter: directed bursts, a round-robin vector table,
// and a randomized run against a transaction-level model of requesters and the HBM slave.
module tb_hbm_rd_arbiter;

    localparam int NR = 2;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int GW = 1;

    logic              ap_clk = 1'b0;
    logic              areset;
    logic [NR-1:0]     req_arvalid;
    logic [NR*AW-1:0]  req_araddr;
    logic [NR*8-1:0]   req_arlen;
    logic [NR-1:0]     req_arready;
    logic [NR-1:0]     req_rvalid;
    logic [DW-1:0]     req_rdata;
    logic              req_rlast;
    logic [NR-1:0]     req_rready;
    logic              m_axi_arvalid;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic              m_axi_arready;
    logic              m_axi_rvalid;
    logic [DW-1:0]     m_axi_rdata;
    logic              m_axi_rlast;
    logic              m_axi_rready;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              err;

    hbm_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .GID_W(GW)) dut (
        .ap_clk(ap_clk), .areset(areset),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .req_rlast(req_rlast), .req_rready(req_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    always #5 ap_clk = ~ap_clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] vld;
        int         exp_g;
    } rr_vec_t;

    rr_vec_t tbl [8];

    // random-run model state
    logic [1:0]    pend;
    logic [63:0]   paddr [NR];
    logic [7:0]    plen  [NR];
    int            mlast, owner, beats_left, bursts_done, g;
    bit            ar_phase, d_phase, sv_valid;
    logic [63:0]   cur_addr;
    logic [7:0]    cur_len;
    logic [511:0]  sv_data;
    logic [1:0]    exp_ar, exp_rv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input int c);
        oh = 2'(2'b01 << c);
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int rr_pick(input int last, input logic [1:0] p);
        int r;
        r = -1;
        for (int k = 1; k <= NR; k++) begin
            if (r < 0 && p[(last + k) % NR]) r = (last + k) % NR;
        end
        return r;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_arready"}, 64'(req_arready), 64'd0);
        chk({tag, "_rvalid"},  64'(req_rvalid), 64'd0);
        chk_d({tag, "_rdata"}, req_rdata, 512'd0);
        chk({tag, "_rlast"},   64'(req_rlast), 64'd0);
        chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        chk({tag, "_araddr"},  m_axi_araddr, 64'd0);
        chk({tag, "_arlen"},   64'(m_axi_arlen), 64'd0);
        chk({tag, "_rready"},  64'(m_axi_rready), 64'd0);
        chk({tag, "_gid"},     64'(grant_id), 64'd0);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_err"},     64'(err), 64'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
        #1;
        chk_zero("reset");
        @(posedge ap_clk);
        @(posedge ap_clk);
        #2;
        areset = 1'b0;
        #1;
    endtask

    // One request/grant, AR phase with arwait stall cycles, then nbeats R beats.
    task automatic burst(input logic [1:0] vld, input int col, input logic [63:0] addr,
                         input logic [7:0] len, input int arwait, input int nbeats,
                         input int rlast_at, input bit toggle, input logic exp_err);
        int beat, cyc;
        logic [511:0] d;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; req_rready = '0; m_axi_arready = 1'b0;
        for (int c = 0; c < NR; c++) begin
            req_araddr[c*AW +: AW] = (c == col) ? addr : ~addr;
            req_arlen[c*8 +: 8]    = (c == col) ? len : ~len;
        end
        req_arvalid = vld;
        #1;
        chk("grant_arready", 64'(req_arready), 64'(oh(col)));
        chk("grant_idle", 64'(busy), 64'd0);
        @(posedge ap_clk); #1;
        req_arvalid[col] = 1'b0;
        req_rready = '1;
        for (int i = 0; i <= arwait; i++) begin
            m_axi_arready = (i == arwait);
            #1;
            chk("ar_valid", 64'(m_axi_arvalid), 64'd1);
            chk("ar_addr", m_axi_araddr, addr);
            chk("ar_len", 64'(m_axi_arlen), 64'(len));
            chk("ar_gid", 64'(grant_id), 64'(col));
            chk("ar_nopreempt", 64'(req_arready), 64'd0);
            chk("ar_no_rready", 64'(m_axi_rready), 64'd0);
            @(posedge ap_clk); #1;
        end
        m_axi_arready = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < nbeats && cyc < 64) begin
            d = rand_data();
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rlast  = (beat == rlast_at);
            req_rready   = toggle ? ((cyc % 2 == 0) ? oh(col) : ~oh(col)) : 2'b11;
            #1;
            chk("r_valid", 64'(req_rvalid), 64'(oh(col)));
            chk("r_ready", 64'(m_axi_rready), 64'(req_rready[col]));
            chk_d("r_data", req_rdata, d);
            chk("r_last", 64'(req_rlast), 64'(beat == rlast_at));
            chk("r_nopreempt", 64'(req_arready), 64'd0);
            if (req_rready[col]) beat++;
            cyc++;
            @(posedge ap_clk); #1;
        end
        chk("beats_done", 64'(beat), 64'(nbeats));
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; req_rready = '0; req_arvalid = '0;
        #1;
        chk("busy_after", 64'(busy), 64'(!(rlast_at >= 0 && rlast_at < nbeats)));
        chk("err_after", 64'(err), 64'(exp_err));
    endtask

    initial begin
        tbl[0] = '{2'b11, 0};
        tbl[1] = '{2'b11, 1};
        tbl[2] = '{2'b11, 0};
        tbl[3] = '{2'b10, 1};
        tbl[4] = '{2'b10, 1};
        tbl[5] = '{2'b01, 0};
        tbl[6] = '{2'b11, 1};
        tbl[7] = '{2'b01, 0};

        do_reset();

        // basic burst, stalled AR, throttled R on column 1
        burst(2'b01, 0, 64'h1000, 8'd3, 0, 4, 3, 1'b0, 1'b0);
        burst(2'b01, 0, 64'h2000, 8'd2, 5, 3, 2, 1'b0, 1'b0);
        burst(2'b10, 1, 64'h3000, 8'd7, 0, 8, 7, 1'b1, 1'b0);

        // round-robin order; last grant was column 1 here
        for (int i = 0; i < 8; i++) begin
            burst(tbl[i].vld, tbl[i].exp_g, 64'h1000_0000 + 64'(i) * 64'h40,
                  8'd0, 0, 1, 0, 1'b0, 1'b0);
        end

        // overrun: beat arlen without rlast keeps forwarding and flags err
        burst(2'b01, 0, 64'h5000, 8'd1, 0, 3, 2, 1'b0, 1'b1);

        do_reset();
        // early rlast, then err stays set through a clean burst
        burst(2'b01, 0, 64'h6000, 8'd3, 0, 2, 1, 1'b0, 1'b1);
        burst(2'b10, 1, 64'h7000, 8'd0, 0, 1, 0, 1'b0, 1'b1);

        // reset in the middle of an 8-beat burst
        burst(2'b01, 0, 64'h8000, 8'd7, 0, 2, -1, 1'b0, 1'b1);
        req_arvalid = 2'b11; m_axi_rvalid = 1'b1; req_rready = '1; m_axi_rlast = 1'b0;
        #1;
        chk("mid_rvalid", 64'(req_rvalid), 64'd1);
        areset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge ap_clk); #2;
        areset = 1'b0;
        #1;
        chk("post_rst_rready", 64'(m_axi_rready), 64'd0);
        chk("post_rst_rvalid", 64'(req_rvalid), 64'd0);
        chk("post_rst_grant", 64'(req_arready), 64'd1);
        @(posedge ap_clk); #1;
        req_arvalid = '0; m_axi_rvalid = 1'b0;
        #1;
        chk("post_rst_gid", 64'(grant_id), 64'd0);
        chk("post_rst_addr", m_axi_araddr, 64'h8000);

        // randomized run against the transaction model
        do_reset();
        pend = '0; mlast = NR - 1; owner = -1; bursts_done = 0;
        ar_phase = 1'b0; d_phase = 1'b0; sv_valid = 1'b0; beats_left = 0;
        cur_addr = '0; cur_len = '0; sv_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NR; c++) begin
                if (!pend[c] && $urandom_range(0, 3) == 0) begin
                    pend[c]  = 1'b1;
                    paddr[c] = {$urandom, $urandom};
                    plen[c]  = 8'($urandom_range(0, 4));
                end
                req_araddr[c*AW +: AW] = paddr[c];
                req_arlen[c*8 +: 8]    = plen[c];
            end
            req_arvalid   = pend;
            m_axi_arready = 1'($urandom_range(0, 1));
            req_rready    = 2'($urandom_range(0, 3));
            if (d_phase && !sv_valid && $urandom_range(0, 2) != 0) begin
                sv_valid = 1'b1;
                sv_data  = rand_data();
            end
            m_axi_rvalid = sv_valid;
            m_axi_rdata  = sv_data;
            m_axi_rlast  = sv_valid && (beats_left == 1);
            #1;
            g      = (owner < 0 && pend != 2'b00) ? rr_pick(mlast, pend) : -1;
            exp_ar = (g >= 0) ? oh(g) : 2'b00;
            exp_rv = (d_phase && sv_valid) ? oh(owner) : 2'b00;
            chk("rnd_arready", 64'(req_arready), 64'(exp_ar));
            chk("rnd_busy", 64'(busy), 64'(owner >= 0));
            chk("rnd_arvalid", 64'(m_axi_arvalid), 64'(ar_phase));
            if (ar_phase) begin
                chk("rnd_araddr", m_axi_araddr, cur_addr);
                chk("rnd_arlen", 64'(m_axi_arlen), 64'(cur_len));
            end
            chk("rnd_rvalid", 64'(req_rvalid), 64'(exp_rv));
            chk("rnd_rready", 64'(m_axi_rready), 64'(d_phase ? req_rready[owner] : 1'b0));
            chk("rnd_rlast", 64'(req_rlast), 64'(d_phase ? m_axi_rlast : 1'b0));
            if (d_phase && sv_valid) chk_d("rnd_rdata", req_rdata, sv_data);
            chk("rnd_err", 64'(err), 64'd0);
            if (g >= 0) begin
                owner    = g;
                ar_phase = 1'b1;
                cur_addr = paddr[g];
                cur_len  = plen[g];
                pend[g]  = 1'b0;
            end else if (ar_phase && m_axi_arready) begin
                ar_phase   = 1'b0;
                d_phase    = 1'b1;
                beats_left = int'(cur_len) + 1;
            end else if (d_phase && sv_valid && req_rready[owner]) begin
                sv_valid = 1'b0;
                beats_left--;
                if (beats_left == 0) begin
                    d_phase = 1'b0;
                    mlast   = owner;
                    owner   = -1;
                    bursts_done++;
                end
            end
            @(posedge ap_clk); #1;
        end
        chk("rnd_progress", 64'(bursts_done >= 20), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hbm_rd_arbiter.md
Name: hbm_rd_arbiter

Overview:
- Shares one AXI4 read channel (AR + R) to an HBM pseudo-channel between NUM_REQ column read requesters in the CGRA data path.
- Sits between the per-column HBM read ports of data_path and a single m_axi read master.
- Round-robin grant; one burst is in flight at a time; R beats are routed back to the granted column.
- Checks beat count against arlen and flags protocol errors.

Parameters:
- NUM_REQ, 2, number of requesting columns (at least 2).
- ADDR_W, 64, AXI address width.
- DATA_W, 512, AXI data width (phit size).
- GID_W, 1, grant index width; equals clog2(NUM_REQ).

Ports:
- ap_clk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- req_arvalid  in  NUM_REQ  per-column read request valid.
- req_araddr  in  NUM_REQ*ADDR_W  per-column address; column i occupies bits [i*ADDR_W +: ADDR_W].
- req_arlen  in  NUM_REQ*8  per-column burst length minus 1.
- req_arready  out  NUM_REQ  one-hot request accept.
- req_rvalid  out  NUM_REQ  one-hot read-data valid.
- req_rdata  out  DATA_W  read data, broadcast to all columns.
- req_rlast  out  1  last beat, qualified by req_rvalid.
- req_rready  in  NUM_REQ  per-column data ready.
- m_axi_arvalid  out  1  master AR valid.
- m_axi_araddr  out  ADDR_W  master AR address.
- m_axi_arlen  out  8  master AR length.
- m_axi_arready  in  1  master AR ready.
- m_axi_rvalid  in  1  master R valid.
- m_axi_rdata  in  DATA_W  master R data.
- m_axi_rlast  in  1  master R last.
- m_axi_rready  out  1  master R ready.
- grant_id  out  GID_W  index of the column currently owning the channel.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky beat-count mismatch flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - FSM returns to IDLE.
  - All outputs are 0.
  - last_grant = NUM_REQ-1, so column 0 has first priority.
  - Beat counter = 0; err = 0.
  - A burst in flight at reset is abandoned; R beats still arriving afterwards are not forwarded and are not accepted (m_axi_rready=0).
- FSM states:
  - IDLE: if any req_arvalid is high, pick the first set bit searching upward from last_grant+1 with wrap-around. In the same cycle assert req_arready[g] (combinational, single cycle), register araddr/arlen into internal registers, set grant_id=g, go to ADDR. If no request is valid, stay in IDLE.
  - ADDR: m_axi_arvalid=1 with the registered addr/len. These values are held stable until m_axi_arready. On m_axi_arvalid & m_axi_arready, clear the beat counter and go to DATA.
  - DATA:
    - req_rvalid[grant_id] = m_axi_rvalid; all other bits of req_rvalid are 0.
    - m_axi_rready = req_rready[grant_id]; req_rdata = m_axi_rdata; req_rlast = m_axi_rlast. This path is purely combinational (zero latency).
    - Each beat (m_axi_rvalid & m_axi_rready) increments the 9-bit counter.
    - A beat with rlast: go to IDLE and set last_grant = grant_id.
- Latency: request accepted in cycle N; m_axi_arvalid is first high in cycle N+1. At least one IDLE cycle separates consecutive bursts, so a new request arriving during the final beat is granted the following cycle.
- Error rules (err is sticky until reset):
  - rlast on a beat where count != arlen: err set, FSM still returns to IDLE.
  - Beat with count == arlen but no rlast: err set, FSM stays in DATA and forwards beats until rlast.
- Requests are non-preemptive; a requester dropping req_arvalid before its grant is legal and is never granted.
- Outside DATA: req_rvalid=0, m_axi_rready=0, req_rlast=0.
- grant_id holds its value after returning to IDLE until the next grant.

Test Plan:
1. Reset, then column 0 requests addr=0x1000, len=3; arready=1, 4 R beats with rlast on beat 4 -> req_arready[0] pulses 1 cycle; m_axi_arvalid high the next cycle with addr 0x1000, len 3; 4 beats delivered on req_rvalid[0] only; err=0; busy falls after the last beat.
2. Both columns request continuously with len=0 -> grant order 0,1,0,1; each grant separated by ≥1 IDLE cycle; req_arready is always one-hot.
3. m_axi_arready held low for 5 cycles -> m_axi_arvalid, araddr and arlen stay stable for all 5 cycles; FSM enters DATA only on the handshake cycle.
4. Column 1 granted with len=7; req_rready[1] toggles every other cycle -> m_axi_rready mirrors it exactly; 8 beats transferred with no loss or duplication; req_rvalid[0] stays 0 throughout.
5. len=3 but rlast on beat 2 -> err=1 and FSM returns to IDLE; err stays 1 through later clean bursts until areset.
6. areset asserted mid-DATA after beat 2 of 8 -> all outputs drop to 0 asynchronously; after release, a column 0 request is granted first (last_grant=NUM_REQ-1).
